// File: rtl/scatter_pkt_sequencer.sv
// Orders the bias, weight and image host streams onto the single scatter packet input.
// Reports job progress, completion and protocol errors.
module scatter_pkt_sequencer #(
    parameter int NUM_PUS      = 64,
    parameter int NUM_CHANNELS = 3,
    parameter int IMG_SIZE     = 10,
    parameter int WT_ROWS      = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         bias_valid,
    input  logic [127:0] bias_data,
    output logic         bias_ready,
    input  logic         wt_valid,
    input  logic [127:0] wt_data,
    output logic         wt_ready,
    input  logic         img_valid,
    input  logic [127:0] img_data,
    output logic         img_ready,
    output logic         out_valid,
    output logic [127:0] out_data,
    input  logic         out_ready,
    input  logic         channel_ready,
    input  logic         conv_done,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [7:0]   cur_ch
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BIAS      = 3'd1,
        ST_WAIT_CH   = 3'd2,
        ST_WEIGHT    = 3'd3,
        ST_IMAGE     = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    localparam logic [CNT_WIDTH-1:0] BIAS_LAST = CNT_WIDTH'(NUM_PUS - 1);
    localparam logic [CNT_WIDTH-1:0] WT_LAST   = CNT_WIDTH'(NUM_PUS * WT_ROWS - 1);
    localparam logic [CNT_WIDTH-1:0] IMG_LAST  = CNT_WIDTH'(IMG_SIZE * IMG_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [7:0]           CH_LAST   = 8'(NUM_CHANNELS - 1);
    localparam logic [1:0]           TYPE_IMG  = 2'b00;
    localparam logic [1:0]           TYPE_BIAS = 2'b01;
    localparam logic [1:0]           TYPE_WT   = 2'b10;

    // Packet legality: type field must match the phase; image packets must also carry the live channel.
    function automatic logic pkt_ok(input logic [127:0] pkt, input logic [1:0] exp_type,
                                    input logic chk_ch, input logic [7:0] ch);
        logic ok_v;
        ok_v = (pkt[127:126] == exp_type);
        if (chk_ch) begin
            ok_v = ok_v && (pkt[111:104] == ch);
        end else begin
            ok_v = ok_v;
        end
        return ok_v;
    endfunction

    state_t                 state_r, state_s;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_s;
    logic [7:0]             cur_ch_r, cur_ch_s;
    logic                   err_r, err_s;
    logic                   out_valid_r, out_valid_s;
    logic [127:0]           out_data_r, out_data_s;
    logic                   busy_r, done_r;

    logic                   space_s;
    logic                   sel_valid_s;
    logic [127:0]           sel_data_s;
    logic [1:0]             exp_type_s;
    logic                   chk_ch_s;
    logic [CNT_WIDTH-1:0]   last_s;
    logic                   accept_s;
    logic                   good_s;

    // Phase stream selection: which source is granted, what it must look like, and its burst length.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = 128'd0;
        exp_type_s  = TYPE_IMG;
        chk_ch_s    = 1'b0;
        last_s      = CNT_ZERO;
        case (state_r)
            ST_BIAS: begin
                sel_valid_s = bias_valid;
                sel_data_s  = bias_data;
                exp_type_s  = TYPE_BIAS;
                last_s      = BIAS_LAST;
            end
            ST_WEIGHT: begin
                sel_valid_s = wt_valid;
                sel_data_s  = wt_data;
                exp_type_s  = TYPE_WT;
                last_s      = WT_LAST;
            end
            ST_IMAGE: begin
                sel_valid_s = img_valid;
                sel_data_s  = img_data;
                exp_type_s  = TYPE_IMG;
                chk_ch_s    = 1'b1;
                last_s      = IMG_LAST;
            end
            default: begin
                sel_valid_s = 1'b0;
            end
        endcase
    end

    // The single output slot can take a packet when empty or draining this cycle.
    assign space_s    = !out_valid_r || out_ready;
    assign bias_ready = (state_r == ST_BIAS)   && space_s;
    assign wt_ready   = (state_r == ST_WEIGHT) && space_s;
    assign img_ready  = (state_r == ST_IMAGE)  && space_s;
    assign accept_s   = sel_valid_s && space_s;
    assign good_s     = accept_s && pkt_ok(sel_data_s, exp_type_s, chk_ch_s, cur_ch_r);

    // Next-state, counters, error flag and output slot update.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        cur_ch_s    = cur_ch_r;
        err_s       = err_r;
        out_valid_s = out_valid_r && !out_ready;
        out_data_s  = out_data_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    err_s    = 1'b0;
                    cur_ch_s = 8'd0;
                    cnt_s    = CNT_ZERO;
                    state_s  = ST_BIAS;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_BIAS, ST_WEIGHT, ST_IMAGE: begin
                if (accept_s && !good_s) begin
                    err_s = 1'b1;
                end else if (good_s) begin
                    out_valid_s = 1'b1;
                    out_data_s  = sel_data_s;
                    if (cnt_r == last_s) begin
                        cnt_s = CNT_ZERO;
                        if (state_r == ST_BIAS) begin
                            state_s = ST_WAIT_CH;
                        end else if (state_r == ST_WEIGHT) begin
                            state_s = ST_IMAGE;
                        end else if (cur_ch_r == CH_LAST) begin
                            state_s = ST_WAIT_DONE;
                        end else begin
                            cur_ch_s = cur_ch_r + 8'd1;
                            state_s  = ST_WAIT_CH;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_WAIT_CH: begin
                // Weights for the next channel wait until the last image packet has left.
                if (channel_ready && !out_valid_r) begin
                    state_s = ST_WEIGHT;
                end else begin
                    state_s = ST_WAIT_CH;
                end
            end
            ST_WAIT_DONE: begin
                if (conv_done) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (conv_done && (state_r != ST_WAIT_DONE)) begin
            err_s = 1'b1;
        end else begin
            err_s = err_s;
        end
    end

    // State and datapath registers; reset discards any pending output packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            cur_ch_r    <= 8'd0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 128'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            cur_ch_r    <= cur_ch_s;
            err_r       <= err_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            busy_r      <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done_r      <= (state_s == ST_DONE);
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign cur_ch    = cur_ch_r;
    assign err       = err_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
